adder_result_checker: RTL and testbench

ADDER_RESULT_CHECKER -- requirements
Module: adder_result_checker

---
 rtl/adder_check_pkg.sv | 20 ++
 rtl/result_delay_line.sv | 57 +++++
 rtl/adder_result_checker.sv | 121 ++++++++++++
 tb/tb_adder_result_checker.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_check_pkg.sv
// Shared definitions for the adder result checker.
//   state_e : checker FSM states
//   CntW    : width of the tallies and the vector index
//   NoFail  : first_fail_idx value meaning "no failure seen"
//   CntMax  : saturation value of the pass/fail tallies
package adder_check_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain,
    StDone
  } state_e;

  localparam int unsigned CntW = 16;

  localparam logic [CntW-1:0] NoFail = 16'hFFFF;
  localparam logic [CntW-1:0] CntMax = 16'hFFFF;

endpackage

// File: rtl/result_delay_line.sv
// Fixed-depth pipeline that carries an expected-result entry alongside the
// adder under test, so the entry emerges when the DUT outputs become valid.
//   clk, rst          : clock, synchronous active-high reset
//   clear             : synchronous flush of all valid bits
//   in_valid, in_data : entry launched this cycle
//   out_valid, out_data : entry emerging this cycle (DEPTH = 0 is a pass-through)
//   pending           : a valid entry is still in flight behind the emerging one
module result_delay_line #(
  parameter int unsigned DEPTH = 0,
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             pending
);

  if (DEPTH == 0) begin : g_bypass
    logic unused_ctrl;
    assign unused_ctrl = ^{clk, rst, clear};
    assign out_valid   = in_valid;
    assign out_data    = in_data;
    assign pending     = 1'b0;
  end else begin : g_pipe
    logic [DEPTH-1:0] valid_q;
    logic [WIDTH-1:0] data_q [DEPTH];

    always_ff @(posedge clk) begin
      if (rst || clear) begin
        valid_q <= '0;
      end else begin
        valid_q[0] <= in_valid;
        for (int unsigned i = 1; i < DEPTH; i++) valid_q[i] <= valid_q[i-1];
      end
    end

    // Payload needs no reset: it is only ever looked at alongside its valid bit.
    always_ff @(posedge clk) begin
      data_q[0] <= in_data;
      for (int unsigned i = 1; i < DEPTH; i++) data_q[i] <= data_q[i-1];
    end

    // The last stage is emerging now, so only earlier stages count as pending.
    always_comb begin
      pending = 1'b0;
      for (int unsigned i = 0; i + 1 < DEPTH; i++) pending = pending | valid_q[i];
    end

    assign out_valid = valid_q[DEPTH-1];
    assign out_data  = data_q[DEPTH-1];
  end

endmodule

// File: rtl/adder_result_checker.sv
// Scoreboard for an adder under test: computes the expected sum/overflow of each
// applied vector, delays it by the adder's LATENCY (legal 0..8) and tallies
// matches and mismatches against the adder outputs.
//   clk, rst               : clock, synchronous active-high reset
//   start                  : pulse in IDLE/DONE clears tallies and starts a run
//   vec_valid, vec_last    : operands applied this cycle / final vector of the run
//   vec_a, vec_b, vec_cin  : operands applied to the adder
//   dut_sum, dut_overflow  : adder outputs
//   busy, done             : run in progress / run finished
//   err                    : one-cycle pulse per mismatch (registered)
//   pass_count, fail_count : saturating tallies
//   first_fail_idx         : index of the first failing vector, FFFF if none
module adder_result_checker
  import adder_check_pkg::*;
#(
  parameter int unsigned NUM_BITS = 16,
  parameter int unsigned LATENCY  = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                vec_valid,
  input  logic [NUM_BITS-1:0] vec_a,
  input  logic [NUM_BITS-1:0] vec_b,
  input  logic                vec_cin,
  input  logic                vec_last,
  input  logic [NUM_BITS-1:0] dut_sum,
  input  logic                dut_overflow,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic [CntW-1:0]     pass_count,
  output logic [CntW-1:0]     fail_count,
  output logic [CntW-1:0]     first_fail_idx
);

  localparam int unsigned ResW   = NUM_BITS + 1;
  localparam int unsigned EntryW = ResW + CntW;

  state_e          state_q, state_d;
  logic [CntW-1:0] idx_q, pass_q, fail_q, first_fail_q;
  logic            err_q;

  logic              launch, accept, mismatch;
  logic [ResW-1:0]   exp_res, emerge_res;
  logic [CntW-1:0]   emerge_idx;
  logic [EntryW-1:0] emerge_data;
  logic              emerge_valid, pending;

  assign launch  = start && (state_q == StIdle || state_q == StDone);
  assign accept  = vec_valid && (state_q == StRun);
  assign exp_res = {1'b0, vec_a} + {1'b0, vec_b} + ResW'(vec_cin);

  result_delay_line #(
    .DEPTH(LATENCY),
    .WIDTH(EntryW)
  ) u_delay (
    .clk      (clk),
    .rst      (rst),
    .clear    (launch),
    .in_valid (accept),
    .in_data  ({exp_res, idx_q}),
    .out_valid(emerge_valid),
    .out_data (emerge_data),
    .pending  (pending)
  );

  assign {emerge_res, emerge_idx} = emerge_data;
  assign mismatch = emerge_valid && ({dut_overflow, dut_sum} != emerge_res);

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle, StDone: if (start) state_d = StRun;
      // With no latency the final compare happens in the accepting cycle.
      StRun:          if (accept && vec_last) state_d = (LATENCY == 0) ? StDone : StDrain;
      StDrain:        if (!pending) state_d = StDone;
      default:        state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      idx_q        <= '0;
      pass_q       <= '0;
      fail_q       <= '0;
      first_fail_q <= NoFail;
      err_q        <= 1'b0;
    end else begin
      state_q <= state_d;
      if (launch) begin
        idx_q        <= '0;
        pass_q       <= '0;
        fail_q       <= '0;
        first_fail_q <= NoFail;
        err_q        <= 1'b0;
      end else begin
        err_q <= mismatch;
        if (accept) idx_q <= idx_q + 1'b1;
        if (emerge_valid) begin
          if (mismatch) begin
            if (fail_q != CntMax) fail_q <= fail_q + 1'b1;
            // Index FFFF is a legal vector index, so key off the tally instead.
            if (fail_q == '0) first_fail_q <= emerge_idx;
          end else if (pass_q != CntMax) begin
            pass_q <= pass_q + 1'b1;
          end
        end
      end
    end
  end

  assign busy           = (state_q == StRun) || (state_q == StDrain);
  assign done           = (state_q == StDone);
  assign err            = err_q;
  assign pass_count     = pass_q;
  assign fail_count     = fail_q;
  assign first_fail_idx = first_fail_q;

endmodule

// File: tb/tb_adder_result_checker.sv
module tb_adder_result_checker;

  logic        clk = 1'b0;
  logic        rst, start, vec_valid, vec_cin, vec_last;
  logic [15:0] vec_a, vec_b;

  // Fault controls of the modelled adder under test.
  logic [15:0] stuck_mask;
  logic        ovf_zero, flip;

  logic [15:0] sum0, sum2;
  logic        ovf0, ovf2;
  logic [16:0] pipe1, pipe2;

  logic        busy0, done0, err0, busy2, done2, err2;
  logic [15:0] pass0, fail0, ffi0, pass2, fail2, ffi2;

  int checks = 0;
  int errors = 0;
  int err_cnt0 = 0;
  int err_cnt2 = 0;

  logic [15:0] qa[$], qb[$];
  logic        qc[$];

  always #5 clk = ~clk;

  function automatic logic [16:0] faulty_add(input logic [15:0] a, input logic [15:0] b,
                                             input logic cin, input logic [15:0] mask,
                                             input logic ovz, input logic flp);
    logic [16:0] r;
    r = {1'b0, a} + {1'b0, b} + {16'b0, cin};
    r[15:0] = r[15:0] & ~mask;
    if (flp) r[0] = ~r[0];
    if (ovz) r[16] = 1'b0;
    return r;
  endfunction

  assign {ovf0, sum0} = faulty_add(vec_a, vec_b, vec_cin, stuck_mask, ovf_zero, flip);

  always @(posedge clk) begin
    pipe1 <= faulty_add(vec_a, vec_b, vec_cin, stuck_mask, ovf_zero, flip);
    pipe2 <= pipe1;
  end
  assign {ovf2, sum2} = pipe2;

  always @(negedge clk) begin
    if (err0 === 1'b1) err_cnt0 <= err_cnt0 + 1;
    if (err2 === 1'b1) err_cnt2 <= err_cnt2 + 1;
  end

  adder_result_checker #(.NUM_BITS(16), .LATENCY(0)) u_l0 (
    .clk(clk), .rst(rst), .start(start), .vec_valid(vec_valid), .vec_a(vec_a), .vec_b(vec_b),
    .vec_cin(vec_cin), .vec_last(vec_last), .dut_sum(sum0), .dut_overflow(ovf0),
    .busy(busy0), .done(done0), .err(err0), .pass_count(pass0), .fail_count(fail0),
    .first_fail_idx(ffi0)
  );

  adder_result_checker #(.NUM_BITS(16), .LATENCY(2)) u_l2 (
    .clk(clk), .rst(rst), .start(start), .vec_valid(vec_valid), .vec_a(vec_a), .vec_b(vec_b),
    .vec_cin(vec_cin), .vec_last(vec_last), .dut_sum(sum2), .dut_overflow(ovf2),
    .busy(busy2), .done(done2), .err(err2), .pass_count(pass2), .fail_count(fail2),
    .first_fail_idx(ffi2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Plays the queued vectors as one run and checks both checkers against a
  // plain count of which vectors the faulty adder gets wrong.
  task automatic run_q(input string tag, input bit mid_start);
    int          exp_pass = 0;
    int          exp_fail = 0;
    logic [15:0] exp_ffi  = 16'hFFFF;
    int          e0, e2, n, truth;
    logic [16:0] got;
    e0 = err_cnt0;
    e2 = err_cnt2;
    n  = qa.size();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk({tag, "_busy0"}, 32'(busy0), 32'd1);
    chk({tag, "_busy2"}, 32'(busy2), 32'd1);
    for (int i = 0; i < n; i++) begin
      vec_valid = 1'b1;
      vec_a     = qa[i];
      vec_b     = qb[i];
      vec_cin   = qc[i];
      vec_last  = (i == n - 1);
      start     = mid_start && (i == n / 2);
      got   = faulty_add(qa[i], qb[i], qc[i], stuck_mask, ovf_zero, flip);
      truth = int'(qa[i]) + int'(qb[i]) + int'(qc[i]);
      if (int'(got) != truth) begin
        if (exp_fail == 0) exp_ffi = 16'(i);
        exp_fail++;
      end else begin
        exp_pass++;
      end
      tick();
    end
    vec_valid = 1'b0;
    vec_last  = 1'b0;
    start     = 1'b0;
    if (exp_pass > 32'hFFFF) exp_pass = 32'hFFFF;
    chk({tag, "_done0"}, 32'(done0), 32'd1);
    chk({tag, "_pass0"}, 32'(pass0), exp_pass);
    chk({tag, "_fail0"}, 32'(fail0), (exp_fail > 32'hFFFF) ? 32'hFFFF : exp_fail);
    chk({tag, "_ffi0"}, 32'(ffi0), 32'(exp_ffi));
    chk({tag, "_done2_t1"}, 32'(done2), 32'd0);
    tick();
    chk({tag, "_done2_t2"}, 32'(done2), 32'd0);
    tick();
    chk({tag, "_done2"}, 32'(done2), 32'd1);
    chk({tag, "_pass2"}, 32'(pass2), exp_pass);
    chk({tag, "_fail2"}, 32'(fail2), (exp_fail > 32'hFFFF) ? 32'hFFFF : exp_fail);
    chk({tag, "_ffi2"}, 32'(ffi2), 32'(exp_ffi));
    tick();
    chk({tag, "_errs0"}, err_cnt0 - e0, exp_fail);
    chk({tag, "_errs2"}, err_cnt2 - e2, exp_fail);
  endtask

  task automatic set_q3(input logic [15:0] a0, b0, input logic c0,
                        input logic [15:0] a1, b1, input logic c1,
                        input logic [15:0] a2, b2, input logic c2, input int n);
    qa.delete(); qb.delete(); qc.delete();
    qa.push_back(a0); qb.push_back(b0); qc.push_back(c0);
    if (n > 1) begin qa.push_back(a1); qb.push_back(b1); qc.push_back(c1); end
    if (n > 2) begin qa.push_back(a2); qb.push_back(b2); qc.push_back(c2); end
  endtask

  task automatic set_random(input int n);
    qa.delete(); qb.delete(); qc.delete();
    for (int i = 0; i < n; i++) begin
      qa.push_back(16'($urandom));
      qb.push_back(16'($urandom));
      qc.push_back(1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout checks=%0d errors=%0d", checks, errors + 1);
    $fatal(1, "simulation time limit");
  end

  initial begin
    rst = 1'b1; start = 1'b0; vec_valid = 1'b0; vec_last = 1'b0;
    vec_a = '0; vec_b = '0; vec_cin = 1'b0;
    stuck_mask = '0; ovf_zero = 1'b0; flip = 1'b0;
    repeat (3) tick();
    chk("rst_busy0", 32'(busy0), 32'd0);
    chk("rst_done0", 32'(done0), 32'd0);
    chk("rst_err0", 32'(err0), 32'd0);
    chk("rst_pass0", 32'(pass0), 32'd0);
    chk("rst_fail0", 32'(fail0), 32'd0);
    chk("rst_ffi0", 32'(ffi0), 32'hFFFF);
    chk("rst_busy2", 32'(busy2), 32'd0);
    chk("rst_done2", 32'(done2), 32'd0);
    chk("rst_ffi2", 32'(ffi2), 32'hFFFF);
    rst = 1'b0;
    tick();

    // Correct adder, corner operands.
    set_q3(16'h0000, 16'h0000, 1'b0, 16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 16'h0000, 1'b1, 3);
    run_q("clean", 1'b0);

    // Sum bit 4 stuck at zero.
    stuck_mask = 16'h0010;
    set_q3(16'h0010, 16'h0000, 1'b0, 16'h0001, 16'h0001, 1'b0, 16'h0, 16'h0, 1'b0, 2);
    run_q("stuck4", 1'b0);

    // Overflow output forced low.
    stuck_mask = '0;
    ovf_zero   = 1'b1;
    set_q3(16'h8000, 16'h8000, 1'b0, 16'h0, 16'h0, 1'b0, 16'h0, 16'h0, 1'b0, 1);
    run_q("ovf", 1'b0);

    // Vectors offered while DONE must be ignored.
    flip      = 1'b1;
    vec_valid = 1'b1;
    vec_last  = 1'b1;
    repeat (3) tick();
    vec_valid = 1'b0;
    vec_last  = 1'b0;
    tick();
    chk("done_ign_done0", 32'(done0), 32'd1);
    chk("done_ign_fail0", 32'(fail0), 32'd1);
    chk("done_ign_pass0", 32'(pass0), 32'd0);
    chk("done_ign_done2", 32'(done2), 32'd1);
    chk("done_ign_fail2", 32'(fail2), 32'd1);
    chk("done_ign_err2", 32'(err2), 32'd0);

    // Random runs with a random fault and a stray start pulse mid-run.
    flip = 1'b0;
    for (int r = 0; r < 3; r++) begin
      stuck_mask = 16'(1) << $urandom_range(0, 15);
      ovf_zero   = 1'($urandom_range(0, 1));
      set_random(40);
      run_q($sformatf("rand%0d", r), 1'b1);
    end

    // Reset during DRAIN with two vectors still in flight.
    stuck_mask = '0;
    ovf_zero   = 1'b0;
    flip       = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    vec_valid = 1'b1; vec_a = 16'h1234; vec_b = 16'h1111; vec_cin = 1'b0; vec_last = 1'b0;
    tick();
    vec_a = 16'h0F0F; vec_b = 16'h0101; vec_last = 1'b1;
    tick();
    vec_valid = 1'b0;
    vec_last  = 1'b0;
    begin
      int e2;
      e2 = err_cnt2;
      chk("drain_busy2", 32'(busy2), 32'd1);
      rst = 1'b1;
      tick();
      chk("drst_busy2", 32'(busy2), 32'd0);
      chk("drst_done2", 32'(done2), 32'd0);
      chk("drst_err2", 32'(err2), 32'd0);
      chk("drst_fail2", 32'(fail2), 32'd0);
      chk("drst_pass2", 32'(pass2), 32'd0);
      chk("drst_ffi2", 32'(ffi2), 32'hFFFF);
      chk("drst_fail0", 32'(fail0), 32'd0);
      rst = 1'b0;
      repeat (3) tick();
      chk("drst_fail2_after", 32'(fail2), 32'd0);
      chk("drst_errs2", err_cnt2 - e2, 32'd0);
    end

    // Every vector fails: tallies saturate, index wraps past 16 bits.
    flip = 1'b1;
    set_random(65540);
    run_q("sat", 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
